spi_tx_frame: RTL and testbench

Serial transmitter stage sitting directly downstream of the memory/sequencing controller. It accepts one DATA_W-bit word per `load_data` pulse, shifts it out MSB-first as a single SPI mode-0 frame framed by `spi_cs_n`, and returns a one-cycle `done_send` pulse so the controller can advance to the next address. It is write-only, with no MISO, and holds no queue: one frame in flight at a time.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_tx_frame_if.sv | 26 ++
 rtl/spi_half_tick.sv | 28 ++
 rtl/spi_tx_frame.sv | 130 +++++++++++++
 tb/tb_spi_tx_frame.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit path.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_tx_state_t;

  localparam int SPI_FRAME_W = 24;

  // Mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_tx_frame_if.sv
// Controller-side handshake plus SPI pins for one spi_tx_frame instance.
interface spi_tx_frame_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_FRAME_W
) ();

  logic              load_data;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done_send;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;

  modport master (
    output load_data, data_in,
    input  busy, done_send, spi_sclk, spi_mosi, spi_cs_n
  );

  modport slave (
    input  load_data, data_in,
    output busy, done_send, spi_sclk, spi_mosi, spi_cs_n
  );

endinterface

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: pulses tick once every CLK_DIV enabled cycles.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_tx_frame.sv
// Write-only SPI mode-0 frame transmitter, one DATA_W-bit word per load_data.
//
// state | meaning
// IDLE  | CS high, waiting for load_data
// SETUP | CS asserted, MSB on MOSI, waiting for first SCLK rise
// SHIFT | SCLK toggling, one bit per period, shifted on falling SCLK
// HOLD  | last fall done, LSB held until CS release and done_send
module spi_tx_frame
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_FRAME_W,
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_tx_frame_if.slave  bus
);

  localparam int            BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_tx_state_t     state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  // Timer only runs once CS is visibly low, so the first half period is a full CLK_DIV.
  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (!cs_n_q),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_data) begin
          shreg_d   = bus.data_in;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cs_n_q) begin
          cs_n_d = 1'b0;
          busy_d = 1'b1;
          mosi_d = shreg_q[DATA_W-1];
        end else if (tick) begin
          sclk_d  = ~SPI_CPOL;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q != SPI_CPOL) begin
            sclk_d    = SPI_CPOL;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = HOLD;
            end else begin
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
              mosi_d  = shreg_q[DATA_W-2];
            end
          end else begin
            sclk_d = ~SPI_CPOL;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = IDLE;
          // Accepting here gives the 1-cycle CS gap for back-to-back frames.
          if (bus.load_data) begin
            shreg_d   = bus.data_in;
            bit_cnt_d = '0;
            state_d   = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= SPI_CPOL;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done_send = done_q;
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_mosi  = mosi_q;
  assign bus.spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_tx_frame.sv
// Randomized bench for spi_tx_frame against a closed-form waveform model.
module tb_spi_tx_frame;
  import spi_pkg::*;

  localparam int W     = 24;
  localparam int CD    = 4;
  localparam int TEND  = 1 + (2*W + 1)*CD;
  localparam int WS    = 8;
  localparam int CDS   = 1;
  localparam int TENDS = 1 + (2*WS + 1)*CDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_tx_frame_if #(.DATA_W(W))  bus_m ();
  spi_tx_frame_if #(.DATA_W(WS)) bus_s ();

  spi_tx_frame #(.DATA_W(W), .CLK_DIV(CD)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  spi_tx_frame #(.DATA_W(WS), .CLK_DIV(CDS)) u_dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Expected {cs_n, sclk, mosi, busy, done} t cycles after the accepting edge.
  function automatic logic [4:0] exp_wave(int nb, int cd, logic [31:0] word, int t);
    int tend, p, bi;
    tend = 1 + (2*nb + 1)*cd;
    if (t < 1) return 5'b10000;
    if (t >= tend) return {1'b1, 1'b0, 1'b0, 1'b0, (t == tend)};
    p  = (t - 1) / cd;
    bi = p / 2;
    if (bi > nb - 1) bi = nb - 1;
    return {1'b0, (p % 2 == 1), word[nb-1-bi], 1'b1, 1'b0};
  endfunction

  function automatic logic [4:0] obs_m();
    return {bus_m.spi_cs_n, bus_m.spi_sclk, bus_m.spi_mosi, bus_m.busy, bus_m.done_send};
  endfunction

  function automatic logic [4:0] obs_s();
    return {bus_s.spi_cs_n, bus_s.spi_sclk, bus_s.spi_mosi, bus_s.busy, bus_s.done_send};
  endfunction

  task automatic run_frame(input logic [23:0] word, input bit chained, input bit keep_load,
                           input int rej_t, input int abort_rise,
                           input bit chain_next, input logic [23:0] next_word);
    logic [4:0]  e;
    logic [23:0] rx;
    int          nrise, first_rise;
    logic        prev_sclk;
    if (!chained) begin
      bus_m.load_data = 1'b1;
      bus_m.data_in   = word;
      @(posedge clk);
    end
    rx = '0; nrise = 0; first_rise = -1; prev_sclk = 1'b0;
    for (int t = 0; t < TEND; t++) begin
      @(negedge clk);
      e = exp_wave(W, CD, {8'h0, word}, t);
      if (t == 0) e[0] = chained;
      check_val("wave", {27'd0, obs_m()}, {27'd0, e});
      if (bus_m.spi_sclk && !prev_sclk) begin
        rx = {rx[22:0], bus_m.spi_mosi};
        nrise++;
        if (first_rise < 0) first_rise = t;
      end
      prev_sclk = bus_m.spi_sclk;
      if (abort_rise > 0 && nrise == abort_rise) begin
        rst = 1'b1;
        bus_m.load_data = 1'b0;
        #1;
        check_val("rst_mid", {27'd0, obs_m()}, 32'h10);
        repeat (3) begin
          @(negedge clk);
          check_val("rst_hold", {27'd0, obs_m()}, 32'h10);
        end
        rst = 1'b0;
        return;
      end
      if (rej_t > 0 && t == rej_t) begin
        bus_m.load_data = 1'b1;
        bus_m.data_in   = 24'hFFFFFF;
      end else if (!keep_load) begin
        bus_m.load_data = 1'b0;
      end
      if (t == TEND - 1) begin
        bus_m.load_data = chain_next;
        if (chain_next) bus_m.data_in = next_word;
      end
    end
    check_val("nrise", nrise, W);
    check_val("first_rise", first_rise, 1 + CD);
    check_val("rx_word", {8'h0, rx}, {8'h0, word});
    if (!chain_next) begin
      @(negedge clk);
      check_val("done", {27'd0, obs_m()}, {27'd0, exp_wave(W, CD, {8'h0, word}, TEND)});
      @(negedge clk);
      check_val("post_idle", {27'd0, obs_m()}, 32'h10);
    end
  endtask

  task automatic run_small(input logic [7:0] word);
    logic [7:0] rx;
    int         nrise, done_t;
    logic       prev_sclk;
    bus_s.load_data = 1'b1;
    bus_s.data_in   = word;
    @(posedge clk);
    rx = '0; nrise = 0; done_t = -1; prev_sclk = 1'b0;
    for (int t = 0; t <= TENDS + 1; t++) begin
      @(negedge clk);
      bus_s.load_data = 1'b0;
      check_val("s_wave", {27'd0, obs_s()}, {27'd0, exp_wave(WS, CDS, {24'h0, word}, t)});
      if (bus_s.spi_sclk && !prev_sclk) begin
        rx = {rx[6:0], bus_s.spi_mosi};
        nrise++;
      end
      prev_sclk = bus_s.spi_sclk;
      if (bus_s.done_send && done_t < 0) done_t = t;
    end
    check_val("s_nrise", nrise, WS);
    check_val("s_done_t", done_t, 18);
    check_val("s_rx_word", {24'h0, rx}, {24'h0, word});
  endtask

  initial begin
    logic [23:0] wa, wb;
    bus_m.load_data = 1'b0;
    bus_m.data_in   = '0;
    bus_s.load_data = 1'b0;
    bus_s.data_in   = '0;
    repeat (2) @(negedge clk);
    check_val("rst_state", {27'd0, obs_m()}, 32'h10);
    check_val("rst_state_s", {27'd0, obs_s()}, 32'h10);
    rst = 1'b0;

    repeat (100) begin
      @(negedge clk);
      check_val("idle", {27'd0, obs_m()}, 32'h10);
    end

    run_frame(24'hA5C3F0, 1'b0, 1'b0, 0, 0, 1'b0, 24'h0);
    run_frame(24'h123456, 1'b0, 1'b0, 50, 0, 1'b0, 24'h0);
    run_frame(24'h000001, 1'b0, 1'b1, 0, 0, 1'b1, 24'h800000);
    run_frame(24'h800000, 1'b1, 1'b1, 0, 0, 1'b0, 24'h0);

    run_frame(24'($urandom), 1'b0, 1'b0, 0, 10, 1'b0, 24'h0);
    run_frame(24'h000001, 1'b0, 1'b0, 0, 0, 1'b0, 24'h0);

    for (int i = 0; i < 3; i++)
      run_frame(24'($urandom), 1'b0, 1'b0, int'($urandom_range(1, TEND - 2)), 0, 1'b0, 24'h0);
    wa = 24'($urandom);
    wb = 24'($urandom);
    run_frame(wa, 1'b0, 1'b1, 0, 0, 1'b1, wb);
    run_frame(wb, 1'b1, 1'b0, 0, 0, 1'b0, 24'h0);

    run_small(8'h81);
    run_small(8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
